// File: rtl/pc_fetch.sv
// pc_fetch: architectural program counter and instruction-fetch sequencer.
// Latches the selected next PC on controller command and runs the
// instruction-memory read handshake for the current PC. It keeps the fetched
// word in the instruction register and reports misaligned or timed-out
// fetches as one-cycle exception pulses.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  input  logic        pc_wr,
  input  logic        fetch_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_now,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_exc,
  output logic [1:0]  exc_code
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pend_pc;
  logic        pend_vld;
  logic [7:0]  tmo_cnt;

  logic [31:0] pc_eff;
  logic        misaligned;
  logic        fetch_accept;
  logic        misalign_exc;
  logic [7:0]  tmo_cnt_inc;
  logic        req_done;
  logic        req_timeout;
  logic        req_exit;
  logic        pend_take;
  logic [31:0] pend_take_pc;

  // Saturating 8-bit increment for the REQ-cycle counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Decode of the current cycle's events, shared by every register below.
  always_comb begin
    pc_eff       = pc_wr ? pc_next : pc_now;
    misaligned   = (pc_eff[1:0] != 2'b00);
    fetch_accept = (state == IDLE) && fetch_req && !misaligned;
    misalign_exc = (state == IDLE) && fetch_req && misaligned;
    tmo_cnt_inc  = sat_inc8(tmo_cnt);
    req_done     = (state == REQ) && imem_ready;
    req_timeout  = (state == REQ) && !imem_ready && (tmo_cnt_inc == TMO_LIMIT);
    req_exit     = req_done || req_timeout;
    // A pc_wr on the exit edge itself is the newest pending value.
    pend_take    = pc_wr || pend_vld;
    pend_take_pc = pc_wr ? pc_next : pend_pc;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fetch_accept) state_nxt = REQ;
      REQ:  if (req_exit)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM Moore outputs: the request follows the state alone.
  always_comb begin
    imem_req  = (state == REQ);
    busy      = (state == REQ);
    imem_addr = pc_now;
  end

  // Architectural PC and the deferred write captured while a fetch is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_now   <= RESET_PC;
      pend_pc  <= '0;
      pend_vld <= 1'b0;
    end else if (state == IDLE) begin
      if (pc_wr) begin
        pc_now <= pc_next;
      end
    end else if (req_exit) begin
      if (pend_take) begin
        pc_now <= pend_take_pc;
      end
      pend_vld <= 1'b0;
    end else if (pc_wr) begin
      pend_pc  <= pc_next;
      pend_vld <= 1'b1;
    end
  end

  // REQ-cycle counter, cleared when a fetch is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (fetch_accept) begin
      tmo_cnt <= '0;
    end else if ((state == REQ) && !req_exit) begin
      tmo_cnt <= tmo_cnt_inc;
    end
  end

  // Instruction register; valid only while it matches the current PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (pc_wr || misalign_exc) begin
        ir_valid <= 1'b0;
      end
    end else if (req_done) begin
      ir       <= imem_rdata;
      // A pending PC lands on this same edge, so the word no longer matches.
      ir_valid <= !pend_take;
    end else if (req_timeout) begin
      ir_valid <= 1'b0;
    end
  end

  // Exception pulse and sticky exception code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_exc <= 1'b0;
      exc_code  <= 2'b00;
    end else begin
      fetch_exc <= misalign_exc || req_timeout;
      if (misalign_exc) begin
        exc_code <= EXC_MISALIGN;
      end else if (req_timeout) begin
        exc_code <= EXC_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with TIMEOUT=4.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        pc_wr;
  logic        fetch_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_now;
  logic [31:0] ir;
  logic        ir_valid;
  logic        busy;
  logic        fetch_exc;
  logic [1:0]  exc_code;

  int checks = 0;
  int errors = 0;
  int req_cycles;

  pc_fetch #(
    .RESET_PC(32'h0000_3000),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_next   (pc_next),
    .pc_wr     (pc_wr),
    .fetch_req (fetch_req),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .pc_now    (pc_now),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .busy      (busy),
    .fetch_exc (fetch_exc),
    .exc_code  (exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    pc_next    = '0;
    pc_wr      = 1'b0;
    fetch_req  = 1'b0;
    imem_rdata = '0;
    imem_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_pc", pc_now, 32'h0000_3000);
    check("rst_ir", ir, 32'h0);
    check("rst_irv", {31'b0, ir_valid}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_exc", {31'b0, fetch_exc}, 32'h0);
    check("rst_code", {30'b0, exc_code}, 32'h0);
    rst_n = 1'b1;
    step();

    // Fetch at reset PC, ready in the first REQ cycle
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("f1_req", {31'b0, imem_req}, 32'h1);
    check("f1_busy", {31'b0, busy}, 32'h1);
    check("f1_addr", imem_addr, 32'h0000_3000);
    imem_ready = 1'b1;
    imem_rdata = 32'h2408_0005;
    step();
    imem_ready = 1'b0;
    check("f1_ir", ir, 32'h2408_0005);
    check("f1_irv", {31'b0, ir_valid}, 32'h1);
    check("f1_reqdrop", {31'b0, imem_req}, 32'h0);

    // pc_wr and fetch_req together in IDLE
    pc_wr     = 1'b1;
    pc_next   = 32'h0000_3010;
    fetch_req = 1'b1;
    step();
    pc_wr     = 1'b0;
    fetch_req = 1'b0;
    check("f2_req", {31'b0, imem_req}, 32'h1);
    check("f2_addr", imem_addr, 32'h0000_3010);
    check("f2_pc", pc_now, 32'h0000_3010);
    check("f2_irv", {31'b0, ir_valid}, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'hAABB_CCDD;
    step();
    imem_ready = 1'b0;
    check("f2_ir", ir, 32'hAABB_CCDD);
    check("f2_irv_done", {31'b0, ir_valid}, 32'h1);

    // Back-to-back fetch in the cycle right after completion
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("b2b_req", {31'b0, imem_req}, 32'h1);
    imem_ready = 1'b1;
    imem_rdata = 32'h1111_2222;
    step();
    imem_ready = 1'b0;
    check("b2b_ir", ir, 32'h1111_2222);
    check("b2b_irv", {31'b0, ir_valid}, 32'h1);

    // Misaligned fetch
    pc_wr     = 1'b1;
    pc_next   = 32'h0000_3006;
    fetch_req = 1'b1;
    step();
    pc_wr     = 1'b0;
    fetch_req = 1'b0;
    check("mis_req", {31'b0, imem_req}, 32'h0);
    check("mis_exc", {31'b0, fetch_exc}, 32'h1);
    check("mis_code", {30'b0, exc_code}, 32'h1);
    check("mis_pc", pc_now, 32'h0000_3006);
    check("mis_ir", ir, 32'h1111_2222);
    check("mis_irv", {31'b0, ir_valid}, 32'h0);
    step();
    check("mis_exc_end", {31'b0, fetch_exc}, 32'h0);
    check("mis_code_hold", {30'b0, exc_code}, 32'h1);

    // Timeout with ready never asserted
    pc_wr     = 1'b1;
    pc_next   = 32'h0000_3020;
    fetch_req = 1'b1;
    step();
    pc_wr     = 1'b0;
    fetch_req = 1'b0;
    req_cycles = 0;
    while (imem_req && req_cycles < 20) begin
      req_cycles++;
      step();
    end
    check("tmo_cycles", 32'(req_cycles), 32'd4);
    check("tmo_exc", {31'b0, fetch_exc}, 32'h1);
    check("tmo_code", {30'b0, exc_code}, 32'h2);
    check("tmo_irv", {31'b0, ir_valid}, 32'h0);
    check("tmo_pc", pc_now, 32'h0000_3020);
    step();
    check("tmo_exc_end", {31'b0, fetch_exc}, 32'h0);

    // Deferred pc_wr during REQ, overwritten once, applied on completion
    pc_wr     = 1'b1;
    pc_next   = 32'h0000_3040;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    pc_next   = 32'h0000_5000;
    step();
    pc_next   = 32'h0000_4180;
    step();
    pc_wr     = 1'b0;
    pc_next   = 32'h0;
    check("def_pc_hold", pc_now, 32'h0000_3040);
    check("def_addr", imem_addr, 32'h0000_3040);
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ready = 1'b0;
    check("def_ir", ir, 32'h1234_5678);
    check("def_pc", pc_now, 32'h0000_4180);
    check("def_irv", {31'b0, ir_valid}, 32'h0);
    check("def_reqdrop", {31'b0, imem_req}, 32'h0);
    check("def_noexc", {31'b0, fetch_exc}, 32'h0);

    // Reset asserted mid-REQ
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("rr_req", {31'b0, imem_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_req_drop", {31'b0, imem_req}, 32'h0);
    check("rr_pc", pc_now, 32'h0000_3000);
    check("rr_ir", ir, 32'h0);
    check("rr_exc", {31'b0, fetch_exc}, 32'h0);
    step();
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    imem_ready = 1'b0;
    check("rr_late_ir", ir, 32'h0);
    check("rr_late_irv", {31'b0, ir_valid}, 32'h0);
    check("rr_late_req", {31'b0, imem_req}, 32'h0);
    check("rr_late_code", {30'b0, exc_code}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
